// File: rtl/axi_stream_packetizer.sv
// Frames an unframed AXI-stream into packets of pkt_len words, asserting tlast on each packet's final word.
// Define PKTZR_HEADER_EN to prepend a {seq,len} header word to every packet.
module axi_stream_packetizer #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  output logic             o_tlast,
  input  logic             o_tready,
  output logic [15:0]      pkt_count
);

  typedef enum logic [1:0] {START, HDR, DATA} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [LEN_W-1:0] word_cnt, word_cnt_nxt;
  logic [15:0]      seq, seq_nxt;
  logic [WIDTH-1:0] tdata_nxt;
  logic             tvalid_nxt, tlast_nxt;
  logic             out_free, in_hs, last_word;

  assign out_free  = !o_tvalid || o_tready;
  assign in_hs     = i_tvalid && i_tready;
  assign last_word = (word_cnt == len_q - LEN_W'(1));

`ifdef PKTZR_HEADER_EN
  logic [15:0] len16;
  assign len16 = 16'(len_q);
`endif

  always_comb begin
    state_nxt    = state;
    len_nxt      = len_q;
    word_cnt_nxt = word_cnt;
    seq_nxt      = seq;
    tdata_nxt    = o_tdata;
    tvalid_nxt   = o_tvalid;
    tlast_nxt    = o_tlast;
    i_tready     = 1'b0;
    case (state)
      START: begin
        len_nxt = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
        // The final word of the previous packet may drain during the bubble.
        if (out_free) tvalid_nxt = 1'b0;
`ifdef PKTZR_HEADER_EN
        state_nxt = HDR;
`else
        state_nxt = DATA;
`endif
      end
`ifdef PKTZR_HEADER_EN
      HDR: begin
        if (out_free) begin
          tdata_nxt  = WIDTH'({seq, len16});
          tvalid_nxt = 1'b1;
          tlast_nxt  = 1'b0;
          state_nxt  = DATA;
        end
      end
`endif
      DATA: begin
        i_tready = out_free && !reset;
        if (in_hs) begin
          tdata_nxt  = i_tdata;
          tvalid_nxt = 1'b1;
          tlast_nxt  = last_word;
          if (last_word) begin
            word_cnt_nxt = '0;
            seq_nxt      = seq + 16'd1;
            state_nxt    = START;
          end else begin
            word_cnt_nxt = word_cnt + LEN_W'(1);
          end
        end else if (out_free) begin
          tvalid_nxt = 1'b0;
        end
      end
      default: state_nxt = START;
    endcase
  end

  // Clear flushes everything except the completed-packet counter.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state    <= START;
      len_q    <= LEN_W'(1);
      word_cnt <= '0;
      seq      <= '0;
      o_tdata  <= '0;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
    end else begin
      state    <= state_nxt;
      len_q    <= len_nxt;
      word_cnt <= word_cnt_nxt;
      seq      <= seq_nxt;
      o_tdata  <= tdata_nxt;
      o_tvalid <= tvalid_nxt;
      o_tlast  <= tlast_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count <= '0;
    end else if (o_tvalid && o_tready && o_tlast) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_axi_stream_packetizer.sv
// Randomized self-checking bench for axi_stream_packetizer with a packet-level reference model.
// Honours PKTZR_HEADER_EN the same way as the design.
module tb_axi_stream_packetizer;

  localparam int WIDTH = 32;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset, clear;
  logic [LEN_W-1:0] pkt_len;
  logic [WIDTH-1:0] i_tdata;
  logic             i_tvalid, i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tvalid, o_tlast, o_tready;
  logic [15:0]      pkt_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] stim[$];
  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH:0]   obs_q[$];
  logic [WIDTH+1:0] stall_prev_q[$], stall_cur_q[$];
  logic [WIDTH:0]   lat_in_q[$], lat_out_q[$];
  int               exp_pkts;

  axi_stream_packetizer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .pkt_len(pkt_len),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
    .o_tready(o_tready), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // Observe handshakes 1ns before each rising edge, when everything is settled.
  logic             prev_stall = 1'b0, prev_hs = 1'b0;
  logic [WIDTH+1:0] prev_out;
  logic [WIDTH-1:0] prev_in;
  always @(negedge clk) begin
    #4;
    if (prev_stall) begin
      stall_prev_q.push_back(prev_out);
      stall_cur_q.push_back({o_tvalid, o_tlast, o_tdata});
    end
    if (prev_hs) begin
      lat_in_q.push_back({1'b1, prev_in});
      lat_out_q.push_back({o_tvalid, o_tdata});
    end
    if (!reset && !clear && o_tvalid && o_tready) obs_q.push_back({o_tlast, o_tdata});
    prev_stall = !reset && !clear && o_tvalid && !o_tready;
    prev_out   = {o_tvalid, o_tlast, o_tdata};
    prev_hs    = !reset && !clear && i_tvalid && i_tready;
    prev_in    = i_tdata;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic flush_obs();
    obs_q.delete(); stall_prev_q.delete(); stall_cur_q.delete();
    lat_in_q.delete(); lat_out_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; i_tvalid = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    flush_obs();
  endtask

  // Packet k carries len_a words if k < sw, else len_b; zero lengths mean one word.
  task automatic build_expected(input int n, input int len_a, input int len_b, input int sw);
    int w = 0, k = 0, len;
    exp_q.delete();
    while (w < n) begin
      len = (k < sw) ? len_a : len_b;
      if (len < 1) len = 1;
`ifdef PKTZR_HEADER_EN
      exp_q.push_back({1'b0, 16'(k), 16'(len)});
`endif
      for (int j = 0; j < len && w < n; j++) begin
        exp_q.push_back({(j == len - 1), stim[w]});
        w++;
      end
      k++;
    end
`ifdef PKTZR_HEADER_EN
    len = (k < sw) ? len_a : len_b;
    if (len < 1) len = 1;
    exp_q.push_back({1'b0, 16'(k), 16'(len)});
`endif
    exp_pkts = k;
  endtask

  task automatic drive(input int n, input int vpct, input int rpct,
                       input int chg_at, input logic [LEN_W-1:0] chg_val);
    int idx = 0, cyc = 0;
    bit took = 1'b0;
    while (idx < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (took) begin i_tvalid = 1'b0; took = 1'b0; end
      if (idx == chg_at) pkt_len = chg_val;
      o_tready = ($urandom_range(0, 99) < rpct);
      if (!i_tvalid && ($urandom_range(0, 99) < vpct)) begin
        i_tvalid = 1'b1;
        i_tdata  = stim[idx];
      end
      #4;
      if (i_tvalid && i_tready) begin idx++; took = 1'b1; end
    end
    if (idx < n) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL drive_timeout accepted %0d required %0d", idx, n);
    end
    @(negedge clk);
    i_tvalid = 1'b0;
  endtask

  task automatic drain();
    repeat (8) begin
      @(negedge clk);
      o_tready = 1'b1; i_tvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; i_tvalid = 1'b1; o_tready = 1'b1;
    #1;
    n_cmp++; if (i_tready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_itready got %b want 0", i_tready); end
    repeat (2) @(negedge clk);
    n_cmp++; if (o_tvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_tvalid got %b want 0", o_tvalid); end
    n_cmp++; if (o_tlast !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_tlast got %b want 0", o_tlast); end
    n_cmp++; if (o_tdata !== '0) begin n_bad++; $display("[TB] FAIL reset_tdata got %h want 0", o_tdata); end
    n_cmp++; if (pkt_count !== 16'd0) begin n_bad++; $display("[TB] FAIL reset_pktcount got %0d want 0", pkt_count); end
    i_tvalid = 1'b0; reset = 1'b0;
  endtask

  task automatic test_basic();
    pkt_len = 4;
    do_reset();
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(WIDTH'(i));
    drive(12, 100, 100, -1, '0);
    drain();
    build_expected(12, 4, 4, 0);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL basic_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (pkt_count !== 16'd3) begin n_bad++; $display("[TB] FAIL basic_pktcount got %0d want 3", pkt_count); end
  endtask

  task automatic test_len_zero();
    pkt_len = 0;
    do_reset();
    stim.delete();
    stim.push_back($urandom); stim.push_back($urandom);
    drive(2, 100, 100, -1, '0);
    drain();
    build_expected(2, 0, 0, 0);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL lenzero_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL lenzero_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (pkt_count !== 16'd2) begin n_bad++; $display("[TB] FAIL lenzero_pktcount got %0d want 2", pkt_count); end
  endtask

  task automatic test_backpressure();
    pkt_len = 4;
    do_reset();
    stim.delete();
    for (int i = 0; i < 40; i++) stim.push_back($urandom);
    drive(40, 70, 50, -1, '0);
    drain();
    build_expected(40, 4, 4, 0);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL bp_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    foreach (stall_prev_q[i]) begin
      n_cmp++; if (stall_cur_q[i] !== stall_prev_q[i]) begin n_bad++; $display("[TB] FAIL bp_hold[%0d] got %h want %h", i, stall_cur_q[i], stall_prev_q[i]); end
    end
    foreach (lat_in_q[i]) begin
      n_cmp++; if (lat_out_q[i] !== lat_in_q[i]) begin n_bad++; $display("[TB] FAIL bp_latency[%0d] got %h want %h", i, lat_out_q[i], lat_in_q[i]); end
    end
    n_cmp++; if (pkt_count !== 16'd10) begin n_bad++; $display("[TB] FAIL bp_pktcount got %0d want 10", pkt_count); end
  endtask

  task automatic test_reset_mid();
    pkt_len = 4;
    do_reset();
    stim.delete();
    stim.push_back($urandom); stim.push_back($urandom);
    drive(2, 100, 100, -1, '0);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_tvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL rstmid_tvalid got %b want 0", o_tvalid); end
    reset = 1'b0;
    flush_obs();
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back($urandom);
    drive(4, 100, 100, -1, '0);
    drain();
    build_expected(4, 4, 4, 0);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL rstmid_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL rstmid_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (pkt_count !== 16'd1) begin n_bad++; $display("[TB] FAIL rstmid_pktcount got %0d want 1", pkt_count); end
  endtask

  task automatic test_len_change();
    pkt_len = 4;
    do_reset();
    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back($urandom);
    drive(6, 100, 100, 2, 16'd2);
    drain();
    build_expected(6, 4, 2, 1);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL lenchg_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL lenchg_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (pkt_count !== 16'd2) begin n_bad++; $display("[TB] FAIL lenchg_pktcount got %0d want 2", pkt_count); end
  endtask

  task automatic test_clear();
    pkt_len = 2;
    do_reset();
    stim.delete();
    for (int i = 0; i < 3; i++) stim.push_back($urandom);
    drive(3, 100, 100, -1, '0);
    drain();
    @(negedge clk);
    i_tvalid = 1'b1; i_tdata = 32'hDEAD_BEEF; clear = 1'b1; o_tready = 1'b1;
    #1;
    n_cmp++; if (i_tready !== 1'b1) begin n_bad++; $display("[TB] FAIL clear_itready got %b want 1", i_tready); end
    @(negedge clk);
    clear = 1'b0; i_tvalid = 1'b0;
    n_cmp++; if (o_tvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL clear_tvalid got %b want 0", o_tvalid); end
    n_cmp++; if (pkt_count !== 16'd1) begin n_bad++; $display("[TB] FAIL clear_pktkeep got %0d want 1", pkt_count); end
    flush_obs();
    stim.delete();
    for (int i = 0; i < 2; i++) stim.push_back($urandom);
    drive(2, 100, 100, -1, '0);
    drain();
    build_expected(2, 2, 2, 0);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL clear_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL clear_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (pkt_count !== 16'd2) begin n_bad++; $display("[TB] FAIL clear_pktcount got %0d want 2", pkt_count); end
  endtask

`ifdef PKTZR_HEADER_EN
  task automatic test_header();
    pkt_len = 3;
    do_reset();
    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back($urandom);
    drive(6, 100, 100, -1, '0);
    drain();
    build_expected(6, 3, 3, 0);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL hdr_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL hdr_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() > 4) begin
      n_cmp++; if (obs_q[0] !== 33'h0_0000_0003) begin n_bad++; $display("[TB] FAIL hdr_first got %h want 000000003", obs_q[0]); end
      n_cmp++; if (obs_q[4] !== 33'h0_0001_0003) begin n_bad++; $display("[TB] FAIL hdr_second got %h want 000010003", obs_q[4]); end
    end else begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL hdr_present got %0d words want at least 5", obs_q.size());
    end
  endtask
`endif

  initial begin
    reset = 1'b0; clear = 1'b0; pkt_len = 4;
    i_tdata = '0; i_tvalid = 1'b0; o_tready = 1'b0;
    test_reset();
    test_basic();
    test_len_zero();
    test_backpressure();
    test_reset_mid();
    test_len_change();
    test_clear();
`ifdef PKTZR_HEADER_EN
    test_header();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
